// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier for signed WIDTH-bit operands.
// One add/subtract-and-shift step per cycle; busy, done and product are registered.
module booth_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH:0]       a_q, a_d;
  logic                 q1_q, q1_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       m_sext;
  logic [WIDTH:0]       a_sum;

  // Next-state, Booth step and output decode.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    a_d       = a_q;
    q1_d      = q1_q;
    count_d   = count_q;
    product_d = product_q;
    m_sext    = {m_q[WIDTH-1], m_q};
    a_sum     = a_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          q1_d    = 1'b0;
          count_d = CW'(WIDTH);
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        case ({q_q[0], q1_q})
          2'b01:   a_sum = a_q + m_sext;
          2'b10:   a_sum = a_q - m_sext;
          default: a_sum = a_q;
        endcase
        // Arithmetic shift of {A,Q,Q_1}: A's sign bit is replicated.
        a_d     = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_d     = {a_sum[0], q_q[WIDTH-1:1]};
        q1_d    = q_q[0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          product_d = {a_d[WIDTH-1:0], q_d};
          state_d   = S_DONE;
        end else begin
          state_d   = S_RUN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      a_q       <= '0;
      q1_q      <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      a_q       <= a_d;
      q1_q      <= q1_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed testbench for booth_mult_seq (WIDTH=16) with hand-computed products.
module tb_booth_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int pass_cnt = 0;
  int total    = 0;

  booth_mult_seq #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents operands with start for one edge; returns at the following negedge.
  task automatic accept(input logic [15:0] m, input logic [15:0] q);
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_mult(input logic [15:0] m, input logic [15:0] q,
                          input logic [31:0] exp, input string name);
    int  n;
    int  bn;
    bit  seen;
    logic [31:0] held;
    n = 1; bn = 0; seen = 1'b0;
    accept(m, q);
    for (int i = 0; i < 40; i++) begin
      if (busy) bn++;
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
      n++;
    end
    total++;
    if (!seen) $display("FAIL %s_done_timeout: no done within 40 cycles, required done", name);
    else pass_cnt++;
    total++;
    if (n !== 17) $display("FAIL %s_latency: got %0d edges, required 17", name, n);
    else pass_cnt++;
    total++;
    if (bn !== 17) $display("FAIL %s_busy_cycles: got %0d, required 17", name, bn);
    else pass_cnt++;
    total++;
    if (product !== exp) $display("FAIL %s_product: got %h, required %h", name, product, exp);
    else pass_cnt++;
    held = product;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_done_width: done=%b busy=%b, required 0 0", name, done, busy);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total++;
    if (product !== held) $display("FAIL %s_hold_idle: got %h, required %h", name, product, held);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; multiplicand = 16'd3; multiplier = 16'd3;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0)
      $display("FAIL reset_state: busy=%b done=%b product=%h, required 0 0 0", busy, done, product);
    else pass_cnt++;
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL reset_no_accept: busy=%b, required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_mult(16'd3, 16'd5, 32'h0000000F, "basic");
    run_mult(16'hFFF9, 16'd3, 32'hFFFFFFEB, "mixed");
  endtask

  task automatic test_boundary();
    run_mult(16'h8000, 16'h8000, 32'h40000000, "min_min");
    run_mult(16'h7FFF, 16'h8000, 32'hC0008000, "max_min");
    run_mult(16'h0000, 16'h8000, 32'h00000000, "zero_min");
  endtask

  task automatic test_start_while_busy();
    int pulses;
    logic [31:0] got;
    pulses = 0; got = 32'h0;
    accept(16'd2, 16'd2);
    repeat (3) @(negedge clk);
    multiplicand = 16'd9; multiplier = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin pulses++; got = product; end
      @(negedge clk);
    end
    total++;
    if (pulses !== 1) $display("FAIL busy_start_pulses: got %0d, required 1", pulses);
    else pass_cnt++;
    total++;
    if (got !== 32'h00000004) $display("FAIL busy_start_product: got %h, required %h", got, 32'h00000004);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    pulses = 0;
    accept(16'd100, 16'd100);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0)
      $display("FAIL midrun_reset: busy=%b done=%b product=%h, required 0 0 0", busy, done, product);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    total++;
    if (pulses !== 0) $display("FAIL midrun_no_done: got %0d active cycles, required 0", pulses);
    else pass_cnt++;
    run_mult(16'd100, 16'd100, 32'h00002710, "after_reset");
  endtask

  task automatic test_back_to_back();
    int c;
    int n_done;
    int t0;
    int t1;
    logic [31:0] p0;
    logic [31:0] p1;
    c = 0; n_done = 0; t0 = 0; t1 = 0; p0 = 32'h0; p1 = 32'h0;
    @(negedge clk);
    multiplicand = 16'd1; multiplier = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    multiplicand = 16'd2; multiplier = 16'd2;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        if (n_done == 0) begin t0 = c; p0 = product; end
        else begin t1 = c; p1 = product; end
        n_done++;
        if (n_done == 2) begin start = 1'b0; break; end
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    total++;
    if (n_done !== 2) $display("FAIL b2b_count: got %0d dones, required 2", n_done);
    else pass_cnt++;
    total++;
    if (p0 !== 32'hFFFFFFFF) $display("FAIL b2b_first: got %h, required %h", p0, 32'hFFFFFFFF);
    else pass_cnt++;
    total++;
    if (p1 !== 32'h00000004) $display("FAIL b2b_second: got %h, required %h", p1, 32'h00000004);
    else pass_cnt++;
    total++;
    if ((t1 - t0) !== 18) $display("FAIL b2b_gap: got %0d cycles, required 18", t1 - t0);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || product !== 32'h00000004)
      $display("FAIL b2b_idle: busy=%b product=%h, required 0 %h", busy, product, 32'h00000004);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; multiplicand = 16'h0; multiplier = 16'h0;
    test_reset();
    test_basic();
    test_boundary();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply; sampled only when busy=0.
REQ-005 SHALL have port multiplicand, input, WIDTH bits: two's-complement M operand, sampled with start.
REQ-006 SHALL have port multiplier, input, WIDTH bits: two's-complement Q operand, sampled with start.
REQ-007 SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-008 SHALL have port done, output, 1 bit: high for exactly one cycle when product becomes valid.
REQ-009 SHALL have port product, output, 2*WIDTH bits: two's-complement result, registered and held until the next accepted start.

Function
REQ-010 SHALL implement a 3-state FSM with states IDLE, RUN and DONE.
REQ-011 SHALL accept a request when in IDLE and start=1 at a rising edge, capturing the following on that edge: M=multiplicand; Q=multiplier; A=0 (WIDTH+1 bits); Q_1=0; count=WIDTH. The FSM SHALL then move to RUN.
REQ-012 SHALL perform one Booth iteration per RUN cycle, selected by {Q[0],Q_1}:
- 01: A=A+sext(M)
- 10: A=A-sext(M)
- 00 or 11: A unchanged
REQ-013 SHALL, in the same cycle as REQ-012, arithmetic-right-shift {A,Q,Q_1} by one with A's MSB replicated, and decrement count.
REQ-014 SHALL keep A at WIDTH+1 bits so that M = -2^(WIDTH-1) cannot overflow.
REQ-015 SHALL leave RUN for DONE on the edge that completes iteration WIDTH (count reaches 0).
REQ-016 SHALL load product from the low 2*WIDTH bits of {A,Q} on the edge entering DONE.
REQ-017 SHALL assert done for the single cycle spent in DONE, then return to IDLE unconditionally.
REQ-018 SHALL give a fixed latency: done is high in the cycle following the (WIDTH+1)th rising edge after the accepting edge (17 edges for WIDTH=16), independent of operand values.
REQ-019 SHALL ignore start while busy=1, including during the DONE cycle; operand changes while busy SHALL not affect the result.
REQ-020 SHALL accept back-to-back operations: start held high continuously launches a new multiply on the first IDLE cycle after DONE.
REQ-021 SHALL keep product stable from DONE until the edge after the next accepted start completes; product SHALL not change while in IDLE.
REQ-022 SHALL leave busy and done without combinational paths from start or from the operands.

Reset
REQ-023 SHALL, while rst_n=0 and regardless of clk, set state=IDLE, busy=0, done=0, product=0, and clear A, Q, Q_1, M and count to 0.
REQ-024 SHALL abort any operation in progress when rst_n is asserted mid-RUN or in DONE, without pulsing done; the first start after rst_n deasserts SHALL behave as from power-up.
REQ-025 SHALL not accept start on any edge while rst_n=0.

Verification
REQ-026 SHALL verify basic positive operands: multiplicand=3, multiplier=5, start for one cycle -> done after 17 edges, product=0x0000000F, busy high for 17 cycles.
REQ-027 SHALL verify mixed signs: -7 (0xFFF9) × 3 -> product=0xFFFFFFEB.
REQ-028 SHALL verify the boundary cases:
- 0x8000 × 0x8000 -> 0x40000000
- 0x7FFF × 0x8000 -> 0xC0008000
- 0 × 0x8000 -> 0x00000000
REQ-029 SHALL verify start-while-busy: start 2×2, then at cycle 5 pulse start with 9×9 -> only one done, product=0x00000004; the 9×9 request is not executed.
REQ-030 SHALL verify reset mid-run: start 100×100, assert rst_n=0 at cycle 8 -> busy=0, done never pulses, product=0; then 100×100 -> 0x00002710 after 17 edges.
REQ-031 SHALL verify back-to-back operation: start held high with operands 1×-1 then 2×2 -> done pulses 18 cycles apart with products 0xFFFFFFFF then 0x00000004.
